// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential word fetch over req/ack into a
// small FIFO feeding IF/ID, with redirect flush and in-flight drop.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       ins_valid,
  output logic [31:0]                ins,
  output logic [31:0]                ins_pc,
  output logic [31:0]                ins_pc_plus4,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t          state;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [LW-1:0]   level_q;
  logic [31:0]     fetch_pc;

  logic            push;
  logic            pop;
  logic            space;
  logic [LW-1:0]   nxt_level;

  always_comb begin
    push      = mem_req & mem_ack & (state == BUSY) & ~redirect;
    pop       = ins_valid & ~stall & ~redirect;
    nxt_level = level_q + LW'(push) - LW'(pop);
    if (redirect)
      nxt_level = '0;
    // the request launched at this edge occupies one more slot
    space     = nxt_level < LW'(DEPTH);
  end

  assign ins_valid    = level_q != '0;
  assign level        = level_q;
  assign ins          = ins_valid ? data_q[rd_ptr] : 32'h0;
  assign ins_pc       = ins_valid ? pc_q[rd_ptr] : 32'h0;
  assign ins_pc_plus4 = ins_valid ? pc_q[rd_ptr] + 32'd4 : 32'h0;

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]   <= mem_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level_q  <= '0;
    end else begin
      level_q <= nxt_level;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (redirect) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= redirect_pc & ~32'h3;
      end
      unique case (state)
        IDLE: begin
          if (!redirect && space) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (redirect) begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end else begin
              state   <= DROP;
            end
          end else if (mem_ack) begin
            if (space) begin
              mem_addr <= fetch_pc;
              fetch_pc <= fetch_pc + 32'd4;
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        DROP: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: variable-latency memory responder,
// stall/redirect/reset scenarios with hand-computed expectations.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic [31:0] ins_pc_plus4;
  logic [2:0]  level;

  int n_cmp = 0;
  int n_err = 0;
  int lat   = 0;
  int wcnt  = 0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr    = 32'h0;

  ifetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ins_valid    (ins_valid),
    .ins          (ins),
    .ins_pc       (ins_pc),
    .ins_pc_plus4 (ins_pc_plus4),
    .level        (level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic r;
    @(negedge clk);
    r         = mem_req;
    mem_ack   = r && (wcnt >= lat);
    mem_rdata = ovr_en ? ovr : word(mem_addr);
    @(posedge clk);
    #1;
    if (r && mem_ack)
      wcnt = 0;
    else if (r)
      wcnt++;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    wcnt = 0;
    tick();
    tick();
    wcnt = 0;
    rst  = 1'b0;
  endtask

  initial begin
    #1;
    rst = 1'b1;
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_valid", 32'(ins_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ins", ins, 32'h0);
    check("rst_pc", ins_pc, 32'h0);
    check("rst_pc4", ins_pc_plus4, 32'h0);

    // back-to-back fetch with immediate ack
    do_reset();
    tick();
    check("t1_req", 32'(mem_req), 32'd1);
    check("t1_addr0", mem_addr, 32'h0);
    check("t1_v0", 32'(ins_valid), 32'd0);
    tick();
    check("t1_v1", 32'(ins_valid), 32'd1);
    check("t1_pc0", ins_pc, 32'h0);
    check("t1_pc4", ins_pc_plus4, 32'h4);
    check("t1_ins0", ins, word(32'h0));
    check("t1_addr4", mem_addr, 32'h4);
    tick();
    check("t1_pc1", ins_pc, 32'h4);
    check("t1_lvl", 32'(level), 32'd1);
    tick();
    check("t1_pc2", ins_pc, 32'h8);

    // stall fills the queue, one pop re-opens a slot
    stall = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++)
      tick();
    check("t3_lvl4", 32'(level), 32'd4);
    check("t3_req0", 32'(mem_req), 32'd0);
    check("t3_head", ins_pc, 32'h0);
    tick();
    check("t3_lvl4b", 32'(level), 32'd4);
    check("t3_req0b", 32'(mem_req), 32'd0);
    stall = 1'b0;
    tick();
    stall = 1'b1;
    check("t3_lvl3", 32'(level), 32'd3);
    check("t3_req1", 32'(mem_req), 32'd1);
    check("t3_addr", mem_addr, 32'h10);
    check("t3_head1", ins_pc, 32'h4);
    tick();
    check("t3_lvl4c", 32'(level), 32'd4);
    check("t3_req0c", 32'(mem_req), 32'd0);

    // three-cycle memory latency
    stall = 1'b0;
    lat   = 2;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 3) begin
        check($sformatf("t2_req_c%0d", c), 32'(mem_req), 32'd1);
        check($sformatf("t2_addr_c%0d", c), mem_addr, 32'h0);
      end
      check($sformatf("t2_v_c%0d", c), 32'(ins_valid),
            32'((c == 4) || (c == 7)));
      if (c == 4) begin
        check("t2_pc_c4", ins_pc, 32'h0);
        check("t2_addr_c4", mem_addr, 32'h4);
      end
      if (c == 7) begin
        check("t2_pc_c7", ins_pc, 32'h4);
        check("t2_addr_c7", mem_addr, 32'h8);
      end
    end

    // redirect while request for 0x8 is unacked
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("t4_v", 32'(ins_valid), 32'd0);
    check("t4_lvl", 32'(level), 32'd0);
    check("t4_hold_req", 32'(mem_req), 32'd1);
    check("t4_hold_addr", mem_addr, 32'h8);
    ovr_en = 1'b1;
    ovr    = 32'hDEAD_BEEF;
    tick();
    check("t4_v2", 32'(ins_valid), 32'd0);
    tick();
    ovr_en = 1'b0;
    check("t4_v3", 32'(ins_valid), 32'd0);
    check("t4_req_drop", 32'(mem_req), 32'd0);
    tick();
    check("t4_req_new", 32'(mem_req), 32'd1);
    check("t4_addr_new", mem_addr, 32'h100);
    lat = 0;
    tick();
    check("t4_v4", 32'(ins_valid), 32'd1);
    check("t4_pc", ins_pc, 32'h100);
    check("t4_ins", ins, word(32'h100));

    // redirect on the same edge as an ack
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check("t5_v", 32'(ins_valid), 32'd0);
    check("t5_lvl", 32'(level), 32'd0);
    check("t5_req", 32'(mem_req), 32'd0);
    tick();
    check("t5_req1", 32'(mem_req), 32'd1);
    check("t5_addr", mem_addr, 32'h200);
    tick();
    check("t5_pc", ins_pc, 32'h200);
    check("t5_pc4", ins_pc_plus4, 32'h204);
    check("t5_ins", ins, word(32'h200));

    // asynchronous reset mid-transaction
    stall = 1'b1;
    tick();
    check("t6_lvl2", 32'(level), 32'd2);
    check("t6_busy", 32'(mem_req), 32'd1);
    check("t6_addr", mem_addr, 32'h208);
    lat = 5;
    #2;
    rst = 1'b1;
    #1;
    check("t6_req_async", 32'(mem_req), 32'd0);
    check("t6_v_async", 32'(ins_valid), 32'd0);
    check("t6_lvl_async", 32'(level), 32'd0);
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    lat   = 0;
    wcnt  = 0;
    tick();
    check("t6_restart", mem_addr, 32'h0);
    check("t6_restart_req", 32'(mem_req), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    check("t6_idle", 32'(mem_req), 32'd0);
    tick();
    check("t6_wrap_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    check("t6_wrap_pc", ins_pc, 32'hFFFF_FFFC);
    check("t6_wrap_pc4", ins_pc_plus4, 32'h0);
    check("t6_wrap_next", mem_addr, 32'h0);
    tick();
    check("t6_wrap_pc0", ins_pc, 32'h0);
    check("t6_wrap_pc04", ins_pc_plus4, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end. Sits directly upstream of the IF/ID pipeline register and replaces the zero-latency instruction ROM path.
- Issues sequential word fetches to a variable-latency instruction memory over a req/ack handshake and buffers returned words in a small FIFO.
- Presents the oldest instruction and its PC to IF/ID.
- Accepts a redirect from branch/jump resolution, which flushes the queue and restarts fetch at the new PC.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
mem_req  out  1  fetch request to instruction memory, registered
mem_addr  out  32  word address of current request, registered, low 2 bits always 0
mem_ack  in  1  memory accepts and returns data this cycle; meaningful only while mem_req=1
mem_rdata  in  32  instruction word, valid when mem_req & mem_ack
stall  in  1  IF/ID hold; head entry not consumed
redirect  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC, low 2 bits ignored (forced 0)
ins_valid  out  1  queue non-empty
ins  out  32  head instruction word; 0 when empty
ins_pc  out  32  PC of head instruction; 0 when empty
ins_pc_plus4  out  32  ins_pc + 4, mod 2^32; 0 when empty
level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset, asynchronous while rst=1:
  - mem_req=0, mem_addr=0, fetch_pc=RESET_PC
  - FIFO empty, level=0, ins_valid=0, ins/ins_pc/ins_pc_plus4=0
  - state=IDLE
- Handshake:
  - Exactly one request outstanding at most.
  - Once mem_req=1, mem_req and mem_addr hold stable until the cycle mem_ack=1.
  - Transfer occurs on the edge where mem_req & mem_ack.
  - mem_ack while mem_req=0 is ignored.
- Space rule: a new request may be launched at an edge only if the post-edge occupancy plus the new request is ≤ DEPTH. The outstanding request counts against space.
- States:
  - IDLE: mem_req=0.
    - If space, next cycle mem_req=1 with mem_addr=fetch_pc, fetch_pc+=4, go to BUSY.
    - First request appears the cycle after rst deasserts.
  - BUSY: waiting for ack.
    - On ack: push mem_rdata with PC=mem_addr.
    - If space remains after this edge's push/pop, immediately re-issue at fetch_pc (back-to-back, no bubble) and stay BUSY.
    - Otherwise drop mem_req and go to IDLE.
  - DROP: a redirect arrived while a request was outstanding and unacked.
    - Keep mem_req/mem_addr unchanged until ack.
    - Discard the returned data.
    - Then behave as IDLE with the redirected fetch_pc.
- Consumption:
  - Pop when ins_valid & !stall.
  - Push and pop on the same edge leave level unchanged.
  - Push to an empty FIFO: ins_valid=1 the cycle after the ack.
- Redirect (highest priority):
  - At the edge with redirect=1, FIFO is emptied (ins_valid=0 next cycle) and any pop/push of that edge is discarded.
  - fetch_pc=redirect_pc & ~3.
  - If BUSY and mem_ack=0: go to DROP.
  - If BUSY and mem_ack=1: data discarded, go to IDLE.
  - If IDLE or DROP: stay or go IDLE/DROP accordingly; DROP retains the old address.
  - Redirect in consecutive cycles: the last one wins.
- Address arithmetic: 32-bit, wraps 0xFFFF_FFFC → 0x0000_0000 without error.
- Full: no request issued while level=DEPTH, or while level=DEPTH-1 with a request outstanding.
- Reset mid-transaction: mem_req drops immediately (asynchronously); the memory must tolerate an abandoned request.
- Outputs ins/ins_pc/ins_pc_plus4 are combinational from the FIFO head register file. No output changes except on clk edges or rst.

Test Plan:
1. Reset release, RESET_PC=0, mem_ack tied 1 → mem_req=1 addr 0x0 in cycle 1. Words at 0x0, 0x4, 0x8 are pushed back-to-back. ins_valid=1 in cycle 2 with ins_pc=0x0 and ins_pc_plus4=0x4.
2. mem_ack delayed 3 cycles per request, stall=0 → mem_addr held stable for 3 cycles. ins_valid pulses once per word; ins_pc sequence 0x0, 0x4, 0x8.
3. stall=1 held, ack immediate, DEPTH=4 → exactly 4 words buffered, level=4, mem_req=0. Release stall for 1 cycle → level=3 and a new request for 0x10 issues.
4. Redirect to 0x100 while a request for 0x8 is outstanding, ack arrives 2 cycles later with 0xDEAD_BEEF → that word is never presented. The next request is 0x100, and the first valid ins_pc=0x100.
5. Redirect to 0x200 on the same edge as an ack, with stall=0 and a non-empty FIFO → queue empty next cycle, acked data dropped. Next mem_addr=0x200 with no intervening issue of the old sequence.
6. Assert rst for 1 cycle mid-BUSY with level=2 → mem_req, ins_valid and level go 0 immediately. After release, fetch restarts at RESET_PC; fetch_pc wrap from 0xFFFF_FFFC → 0x0 is verified via redirect.
